// File: rtl/adc_capture_ctrl_pkg.sv
// adc_capture_ctrl_pkg: UART command/status codes and capture FSM states
// shared by the capture controller, its channel counters and benches.
package adc_capture_ctrl_pkg;

    localparam int UART_WIDTH = 8;

    localparam logic [UART_WIDTH-1:0] STRT_ADC = 8'h53;
    localparam logic [UART_WIDTH-1:0] STOP_ADC = 8'h50;
    localparam logic [UART_WIDTH-1:0] ADC_RD   = 8'h52;
    localparam logic [UART_WIDTH-1:0] ST_IDLE  = 8'h49;
    localparam logic [UART_WIDTH-1:0] ST_BUSY  = 8'h42;
    localparam logic [UART_WIDTH-1:0] ST_ABORT = 8'h41;
    localparam logic [UART_WIDTH-1:0] ST_ARMED = 8'h4D;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } cap_state_e;

endpackage

// File: rtl/adc_capture_ctrl_ch_counter.sv
// adc_ch_counter: per-channel store index and decimation phase.
// Ports: clk, rst (sync, active-low), clr, hit (accepted sample),
// offs (RAM offset in region), keep (sample is stored), full, full_nxt.
module adc_ch_counter
    import adc_capture_ctrl_pkg::*;
#(
    parameter int SAMPLES = 512,
    parameter int DECIM   = 1,
    parameter int IDX_W   = $clog2(SAMPLES) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             hit,
    output logic [IDX_W-2:0] offs,
    output logic             keep,
    output logic             full,
    output logic             full_nxt
);

    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(SAMPLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLES - 1);
    localparam logic [7:0]       DEC_LAST = 8'(DECIM - 1);

    logic [IDX_W-1:0] idx;
    logic [7:0]       dec;

    assign offs = idx[IDX_W-2:0];
    assign full = (idx == IDX_MAX);
    assign keep = (dec == 8'd0);

    // Lets the FSM leave CAPTURE on the same edge as the last write.
    assign full_nxt = full | (hit & keep & (idx == IDX_LAST));

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            idx <= '0;
            dec <= '0;
        end else if (hit) begin
            dec <= (dec == DEC_LAST) ? 8'd0 : dec + 8'd1;
            if (keep) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: bins XADC samples of enabled channels into per-channel
// RAM regions with decimation; UART start/stop command and status byte.
// Ports: clk, rst (sync active-low), command, ch_mask, s_valid/s_data/
// s_chan sample stream, ram_we/ram_addr/ram_din write port, status.
// Build option ADC_CAP_TRIG_EN: adds trig_level and an ARM state that
// waits for a rising ch0 crossing before capturing.
module adc_capture_ctrl
    import adc_capture_ctrl_pkg::*;
#(
    parameter int ADC_WIDTH = 12,
    parameter int NUM_CH    = 4,
    parameter int SAMPLES   = 512,
    parameter int DECIM     = 1,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int ADDR_W    = $clog2(NUM_CH * SAMPLES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [UART_WIDTH-1:0] command,
    input  logic [NUM_CH-1:0]     ch_mask,
    input  logic                  s_valid,
    input  logic [ADC_WIDTH+3:0]  s_data,
    input  logic [CH_W-1:0]       s_chan,
`ifdef ADC_CAP_TRIG_EN
    input  logic [ADC_WIDTH-1:0]  trig_level,
`endif
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [ADC_WIDTH-1:0]  ram_din,
    output logic [UART_WIDTH-1:0] status
);

    localparam int LOG_S   = $clog2(SAMPLES);
    localparam int IDX_W   = LOG_S + 1;
    localparam int FULL_AW = CH_W + LOG_S;
    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

`ifdef ADC_CAP_TRIG_EN
    localparam cap_state_e            RUN_ST  = S_ARM;
    localparam logic [UART_WIDTH-1:0] RUN_STS = ST_ARMED;
`else
    localparam cap_state_e            RUN_ST  = S_CAPTURE;
    localparam logic [UART_WIDTH-1:0] RUN_STS = ST_BUSY;
`endif

    cap_state_e            state;
    cap_state_e            state_nxt;
    logic [UART_WIDTH-1:0] status_nxt;
    logic [NUM_CH-1:0]     mask_q;
    logic                  strt_q;
    logic                  is_strt;
    logic                  is_stop;
    logic                  start;
    logic                  clr;
    logic                  take;
    logic                  trig_take;
    logic                  wr;
    logic                  in_range;
    logic                  ch_en;
    logic                  all_done;
    logic [NUM_CH-1:0]     hit;
    logic [NUM_CH-1:0]     keep;
    logic [NUM_CH-1:0]     full;
    logic [NUM_CH-1:0]     full_nxt;
    logic [NUM_CH-1:0][LOG_S-1:0] offs;
    logic [ADC_WIDTH-1:0]  sample;
    logic [FULL_AW-1:0]    addr_full;
    logic                  unused_lsb;

    assign sample     = s_data[ADC_WIDTH+3:4];
    assign unused_lsb = ^s_data[3:0];

    assign is_strt = (command == STRT_ADC);
    assign is_stop = (command == STOP_ADC);
    // Edge of the registered compare: a held command starts once only.
    assign start   = is_strt & ~strt_q;

    assign in_range = ({1'b0, s_chan} < NUM_CH_L);
    assign ch_en    = in_range && mask_q[s_chan] && !full[s_chan];

`ifdef ADC_CAP_TRIG_EN
    logic [ADC_WIDTH-1:0] prev_q;
    logic                 prev_vld;
    logic                 ch0_smp;
    logic                 trig_hit;

    assign ch0_smp  = s_valid && (s_chan == '0);
    assign trig_hit = ch0_smp && prev_vld &&
                      (prev_q < trig_level) &&
                      (trig_level <= sample);
    assign trig_take = (state == S_ARM) & trig_hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q   <= '0;
            prev_vld <= 1'b0;
        end else if (clr) begin
            prev_vld <= 1'b0;
        end else if (state == S_ARM && ch0_smp) begin
            prev_q   <= sample;
            prev_vld <= 1'b1;
        end
    end
`else
    assign trig_take = 1'b0;
`endif

    // Stop in the same cycle as a sample wins: the sample is dropped.
    assign take = s_valid & ch_en & ~is_stop &
                  ((state == S_CAPTURE) | trig_take);
    assign wr   = take & keep[s_chan];

    always_comb begin
        hit = '0;
        if (take) begin
            hit[s_chan] = 1'b1;
        end
    end

    assign all_done = &(full_nxt | ~mask_q);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        adc_ch_counter #(
            .SAMPLES (SAMPLES),
            .DECIM   (DECIM),
            .IDX_W   (IDX_W)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .hit      (hit[c]),
            .offs     (offs[c]),
            .keep     (keep[c]),
            .full     (full[c]),
            .full_nxt (full_nxt[c])
        );
    end

    always_comb begin
        state_nxt  = state;
        status_nxt = status;
        clr        = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (|ch_mask) begin
                        clr        = 1'b1;
                        state_nxt  = RUN_ST;
                        status_nxt = RUN_STS;
                    end else begin
                        state_nxt  = S_IDLE;
                        status_nxt = ST_ABORT;
                    end
                end else if (is_stop && state == S_DONE) begin
                    state_nxt  = S_IDLE;
                    status_nxt = ST_IDLE;
                end
            end
            S_ARM: begin
                if (is_stop) begin
                    state_nxt  = S_IDLE;
                    status_nxt = ST_ABORT;
                end else if (trig_take) begin
                    state_nxt  = S_CAPTURE;
                    status_nxt = ST_BUSY;
                end
            end
            S_CAPTURE: begin
                if (is_stop) begin
                    state_nxt  = S_IDLE;
                    status_nxt = ST_ABORT;
                end else if (all_done) begin
                    state_nxt  = S_DONE;
                    status_nxt = ADC_RD;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            status <= ST_IDLE;
            mask_q <= '0;
            strt_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            status <= status_nxt;
            strt_q <= is_strt;
            if (clr) begin
                mask_q <= ch_mask;
            end
        end
    end

    assign addr_full = {s_chan, offs[s_chan]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            ram_we <= wr;
            if (wr) begin
                ram_addr <= addr_full[ADDR_W-1:0];
                ram_din  <= sample;
            end
        end
    end

endmodule
